// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } rx_state_e;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Per-bit tick counter and 3-sample majority vote around the bit centre.
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int unsigned OVERSAMPLE = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic rx,
  output logic sample_valid,
  output logic sample_bit
);

  localparam int unsigned H  = OVERSAMPLE / 2;
  localparam int unsigned TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] TickMax = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] TickLo  = TW'(H - 1);
  localparam logic [TW-1:0] TickMid = TW'(H);
  localparam logic [TW-1:0] TickHi  = TW'(H + 1);

  logic [TW-1:0] tick_q;
  logic          s0_q, s1_q;
  logic          valid_q, bit_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_q  <= '0;
      s0_q    <= 1'b1;
      s1_q    <= 1'b1;
      valid_q <= 1'b0;
      bit_q   <= 1'b1;
    end else begin
      if (!run || tick_q == TickMax) begin
        tick_q <= '0;
      end else begin
        tick_q <= tick_q + 1'b1;
      end
      if (run && tick_q == TickLo)  s0_q <= rx;
      if (run && tick_q == TickMid) s1_q <= rx;
      // Third sample is taken live; the registered vote appears at tick H+2.
      valid_q <= run && (tick_q == TickHi);
      if (run && tick_q == TickHi) bit_q <= majority3(s0_q, s1_q, rx);
    end
  end

  assign sample_valid = valid_q;
  assign sample_bit   = bit_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: synchronizer, frame FSM, shift register, parity check and output pulses.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned data_width = 8,
  parameter int unsigned OVERSAMPLE = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic                  PAR_EN,
  input  logic                  PAR_Type,
  output logic [data_width-1:0] P_DATA,
  output logic                  Data_Valid,
  output logic                  PAR_ERR,
  output logic                  STP_ERR,
  output logic                  BUSY
);

  localparam int unsigned CW = $clog2(data_width + 1);
  localparam logic [CW-1:0] LastBit = CW'(data_width - 1);

  rx_state_e             state_q, state_d;
  logic                  rx_m_q, rx_s_q, rx_prev_q;
  logic [CW-1:0]         bit_cnt_q, bit_cnt_d;
  logic [data_width-1:0] shift_q, shift_d;
  logic [data_width-1:0] p_data_q, p_data_d;
  logic                  par_en_q, par_en_d, par_type_q, par_type_d;
  logic                  par_err_q, par_err_d;
  logic                  dv_q, dv_d, perr_q, perr_d, serr_q, serr_d;
  logic                  sample_valid, sample_bit;

  uart_rx_sampler #(
    .OVERSAMPLE(OVERSAMPLE)
  ) u_sampler (
    .clk          (CLK),
    .rst_n        (RST),
    .run          (state_q != StIdle),
    .rx           (rx_s_q),
    .sample_valid (sample_valid),
    .sample_bit   (sample_bit)
  );

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    p_data_d   = p_data_q;
    par_en_d   = par_en_q;
    par_type_d = par_type_q;
    par_err_d  = par_err_q;
    dv_d       = 1'b0;
    perr_d     = 1'b0;
    serr_d     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (rx_prev_q && !rx_s_q) begin
          state_d    = StStart;
          bit_cnt_d  = '0;
          par_en_d   = PAR_EN;
          par_type_d = PAR_Type;
          par_err_d  = 1'b0;
        end
      end
      StStart: begin
        if (sample_valid) state_d = sample_bit ? StIdle : StData;
      end
      StData: begin
        if (sample_valid) begin
          shift_d = data_width'({sample_bit, shift_q} >> 1);
          if (bit_cnt_q == LastBit) begin
            bit_cnt_d = '0;
            state_d   = par_en_q ? StParity : StStop;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      StParity: begin
        if (sample_valid) begin
          par_err_d = sample_bit != ((^shift_q) ^ (par_type_q == PAR_ODD));
          state_d   = StStop;
        end
      end
      StStop: begin
        // Leave at the vote, not the bit end, so a back-to-back start edge is seen.
        if (sample_valid) begin
          state_d = StIdle;
          serr_d  = !sample_bit;
          perr_d  = par_err_q;
          if (sample_bit && !par_err_q) begin
            dv_d     = 1'b1;
            p_data_d = shift_q;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      rx_m_q     <= 1'b1;
      rx_s_q     <= 1'b1;
      rx_prev_q  <= 1'b1;
      state_q    <= StIdle;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      p_data_q   <= '0;
      par_en_q   <= 1'b0;
      par_type_q <= PAR_EVEN;
      par_err_q  <= 1'b0;
      dv_q       <= 1'b0;
      perr_q     <= 1'b0;
      serr_q     <= 1'b0;
    end else begin
      rx_m_q     <= RX_IN;
      rx_s_q     <= rx_m_q;
      rx_prev_q  <= rx_s_q;
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      p_data_q   <= p_data_d;
      par_en_q   <= par_en_d;
      par_type_q <= par_type_d;
      par_err_q  <= par_err_d;
      dv_q       <= dv_d;
      perr_q     <= perr_d;
      serr_q     <= serr_d;
    end
  end

  assign P_DATA     = p_data_q;
  assign Data_Valid = dv_q;
  assign PAR_ERR    = perr_q;
  assign STP_ERR    = serr_q;
  assign BUSY       = state_q != StIdle;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: frames are modelled at bit level and expected pulses queued.
module tb_uart_rx;

  localparam int unsigned OS = 8;

  logic       CLK = 1'b0;
  logic       RST;
  logic       RX_IN;
  logic       PAR_EN;
  logic       PAR_Type;
  logic [7:0] P_DATA;
  logic       Data_Valid;
  logic       PAR_ERR;
  logic       STP_ERR;
  logic       BUSY;

  uart_rx #(
    .data_width (8),
    .OVERSAMPLE (OS)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .RX_IN      (RX_IN),
    .PAR_EN     (PAR_EN),
    .PAR_Type   (PAR_Type),
    .P_DATA     (P_DATA),
    .Data_Valid (Data_Valid),
    .PAR_ERR    (PAR_ERR),
    .STP_ERR    (STP_ERR),
    .BUSY       (BUSY)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        dv;
    logic        perr;
    logic        serr;
    logic [7:0]  data;
    int unsigned cyc;
  } exp_t;

  exp_t        sb_q[$];
  int unsigned cyc = 0;
  int          checks = 0;
  int          failures = 0;
  logic [7:0]  model_pdata = 8'h00;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every output pulse must match the oldest queued expectation.
  always @(negedge CLK) begin
    if (Data_Valid || PAR_ERR || STP_ERR) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_pulse: got dv=%0b perr=%0b serr=%0b expected no pulse",
                 Data_Valid, PAR_ERR, STP_ERR);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("data_valid", 32'(Data_Valid), 32'(e.dv));
        check("par_err", 32'(PAR_ERR), 32'(e.perr));
        check("stp_err", 32'(STP_ERR), 32'(e.serr));
        check("p_data", 32'(P_DATA), 32'(e.data));
        check("latency_cycle", cyc, e.cyc);
        check("busy_at_pulse", 32'(BUSY), 32'd0);
      end
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive_bit(input logic b, input int glitch_off);
    for (int k = 0; k < int'(OS); k++) begin
      RX_IN = (k == glitch_off) ? ~b : b;
      step();
    end
  endtask

  // One frame; the reference outcome comes from counting ones in the word.
  task automatic send_frame(input logic [7:0] data, input logic pen, input logic ptype,
                            input logic flip, input logic stop, input int glitch_bit,
                            input int glitch_off, input int gap, input logic scramble);
    exp_t        e;
    logic        pbit;
    int unsigned bits;
    PAR_EN   = pen;
    PAR_Type = ptype;
    pbit     = logic'($countones(data) % 2) ^ ptype ^ flip;
    bits     = 10 + (pen ? 1 : 0);
    e.perr   = pen && flip;
    e.serr   = !stop;
    e.dv     = !e.perr && !e.serr;
    if (e.dv) model_pdata = data;
    e.data   = model_pdata;
    e.cyc    = cyc + (bits - 1) * OS + 10;
    sb_q.push_back(e);
    drive_bit(1'b0, -1);
    if (scramble) begin
      PAR_EN   = 1'($urandom);
      PAR_Type = 1'($urandom);
    end
    for (int i = 0; i < 8; i++) drive_bit(data[i], (i == glitch_bit) ? glitch_off : -1);
    if (pen) drive_bit(pbit, -1);
    drive_bit(stop, -1);
    RX_IN = 1'b1;
    repeat (gap) step();
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 400 && sb_q.size() != 0; i++) step();
    check(name, sb_q.size(), 0);
  endtask

  initial begin
    logic busy_seen;
    RST      = 1'b0;
    RX_IN    = 1'b1;
    PAR_EN   = 1'b0;
    PAR_Type = 1'b0;
    repeat (3) step();
    check("reset_p_data", 32'(P_DATA), 32'h0);
    check("reset_dv", 32'(Data_Valid), 32'h0);
    check("reset_perr", 32'(PAR_ERR), 32'h0);
    check("reset_serr", 32'(STP_ERR), 32'h0);
    check("reset_busy", 32'(BUSY), 32'h0);
    RST = 1'b1;
    repeat (4) step();

    // Plain frame, no parity.
    send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, -1, -1, 20, 1'b0);
    wait_drain("drain_a5");
    check("a5_busy_after", 32'(BUSY), 32'h0);
    check("a5_p_data_after", 32'(P_DATA), 32'hA5);

    // Even parity: good then bad parity bit.
    send_frame(8'h3C, 1'b1, 1'b0, 1'b0, 1'b1, -1, -1, 12, 1'b0);
    send_frame(8'h3C, 1'b1, 1'b0, 1'b1, 1'b1, -1, -1, 12, 1'b0);
    wait_drain("drain_even");

    // Odd parity: good, then stop bit forced low.
    send_frame(8'h01, 1'b1, 1'b1, 1'b0, 1'b1, -1, -1, 12, 1'b0);
    send_frame(8'h01, 1'b1, 1'b1, 1'b0, 1'b0, -1, -1, 12, 1'b0);
    wait_drain("drain_odd");
    check("held_after_stp_err", 32'(P_DATA), 32'h01);

    // Short low glitch on an idle line.
    RX_IN = 1'b0;
    step();
    step();
    RX_IN = 1'b1;
    busy_seen = 1'b0;
    for (int i = 0; i < int'(OS) + 3; i++) begin
      @(negedge CLK);
      busy_seen |= BUSY;
      if (busy_seen && !BUSY) break;
    end
    check("glitch_busy_seen", 32'(busy_seen), 32'h1);
    check("glitch_busy_drop", 32'(BUSY), 32'h0);
    step();
    repeat (10) step();

    // Glitch inside a data bit, then back-to-back frames.
    send_frame(8'hF0, 1'b0, 1'b0, 1'b0, 1'b1, 6, 5, 12, 1'b0);
    send_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b1, -1, -1, 0, 1'b0);
    send_frame(8'hAA, 1'b0, 1'b0, 1'b0, 1'b1, -1, -1, 12, 1'b0);
    wait_drain("drain_b2b");

    // Reset in the middle of the data bits abandons the frame.
    PAR_EN = 1'b0;
    drive_bit(1'b0, -1);
    drive_bit(1'b1, -1);
    drive_bit(1'b0, -1);
    drive_bit(1'b1, -1);
    RST = 1'b0;
    #1;
    check("midreset_p_data", 32'(P_DATA), 32'h0);
    check("midreset_busy", 32'(BUSY), 32'h0);
    check("midreset_dv", 32'(Data_Valid), 32'h0);
    model_pdata = 8'h00;
    RX_IN = 1'b1;
    repeat (3) step();
    RST = 1'b1;
    repeat (4) step();
    send_frame(8'h7E, 1'b0, 1'b0, 1'b0, 1'b1, -1, -1, 12, 1'b0);
    wait_drain("drain_7e");

    // Randomised frames with mid-frame parity-setting changes.
    for (int n = 0; n < 40; n++) begin
      logic [7:0] d;
      logic       stop;
      int         gap;
      int         gb;
      d    = 8'($urandom);
      stop = ($urandom_range(0, 7) != 0);
      gap  = stop ? int'($urandom_range(0, 12)) : int'($urandom_range(2, 12));
      gb   = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 7)) : -1;
      send_frame(d, 1'($urandom), 1'($urandom), ($urandom_range(0, 5) == 0), stop, gb,
                 int'($urandom_range(1, 6)), gap, 1'b1);
    end
    wait_drain("drain_random");
    repeat (20) step();
    check("final_busy", 32'(BUSY), 32'h0);
    check("final_p_data", 32'(P_DATA), 32'(model_pdata));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
